// File: rtl/decoder_n_to_2n_seq_if.sv
// Request/decode bundle for decoder_n_to_2n_seq.
// Master drives the request side; slave (the decoder) drives status and decode outputs.
interface decoder_n_to_2n_seq_if #(
    parameter int SEL_W   = 2,
    parameter int DWELL_W = 4
);
    localparam int OUT_W = 2**SEL_W;

    logic               en;
    logic               load;
    logic               mode;
    logic [SEL_W-1:0]   sel;
    logic [DWELL_W-1:0] dwell;
    logic               stop;
    logic               ready;
    logic [OUT_W-1:0]   d;
    logic [SEL_W-1:0]   idx;
    logic               wrap;

    modport master (
        output en, load, mode, sel, dwell, stop,
        input  ready, d, idx, wrap
    );

    modport slave (
        input  en, load, mode, sel, dwell, stop,
        output ready, d, idx, wrap
    );
endinterface

// File: rtl/decoder_n_to_2n_seq.sv
// Registered N-to-2^N one-hot decoder with direct-hold and optional dwell-timed scan mode.
// Scan mode, dwell counter and WRAP exist only when DECODER_N_TO_2N_SEQ_SCAN_EN is defined.
//
// state | meaning
// IDLE  | no index selected, D=0, ready for LOAD
// HOLD  | D shows one-hot(IDX) while EN=1, ready for LOAD
// SCAN  | IDX steps every DWELL+1 enabled cycles, not ready
module decoder_n_to_2n_seq #(
    parameter int SEL_W   = 2,
    parameter int DWELL_W = 4
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    decoder_n_to_2n_seq_if.slave    bus
);
    localparam int OUT_W = 2**SEL_W;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HOLD = 2'd1,
        ST_SCAN = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [OUT_W-1:0]   r_d;
    logic [OUT_W-1:0]   w_d_nxt;
    logic [SEL_W-1:0]   r_idx;
    logic [SEL_W-1:0]   w_idx_nxt;
    logic               w_accept;
    logic               w_scan_req;
    logic               w_ready;

`ifdef DECODER_N_TO_2N_SEQ_SCAN_EN
    logic [DWELL_W-1:0] r_cnt;
    logic [DWELL_W-1:0] w_cnt_nxt;
    logic [DWELL_W-1:0] r_dwell;
    logic [DWELL_W-1:0] w_dwell_nxt;
    logic               r_wrap;
    logic               w_wrap_nxt;
    logic               r_ready;

    assign w_scan_req = bus.mode;
    assign w_ready    = r_ready;
    assign bus.wrap   = r_wrap;
`else
    logic               w_unused;

    // Without scan support every LOAD is a direct decode, so MODE and DWELL have no effect.
    assign w_unused   = ^{bus.mode, bus.dwell};
    assign w_scan_req = 1'b0;
    assign w_ready    = 1'b1;
    assign bus.wrap   = 1'b0;
`endif

    // STOP outranks LOAD, so a simultaneous request is never accepted.
    assign w_accept  = bus.load & w_ready & ~bus.stop;
    assign bus.ready = w_ready;
    assign bus.d     = r_d;
    assign bus.idx   = r_idx;

    // State register and registered outputs.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
            r_d     <= '0;
            r_idx   <= '0;
`ifdef DECODER_N_TO_2N_SEQ_SCAN_EN
            r_cnt   <= '0;
            r_dwell <= '0;
            r_wrap  <= 1'b0;
            r_ready <= 1'b1;
`endif
        end else begin
            r_state <= w_state_nxt;
            r_d     <= w_d_nxt;
            r_idx   <= w_idx_nxt;
`ifdef DECODER_N_TO_2N_SEQ_SCAN_EN
            r_cnt   <= w_cnt_nxt;
            r_dwell <= w_dwell_nxt;
            r_wrap  <= w_wrap_nxt;
            r_ready <= (w_state_nxt != ST_SCAN);
`endif
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        if (bus.stop) begin
            w_state_nxt = ST_IDLE;
        end else if (w_accept) begin
            w_state_nxt = w_scan_req ? ST_SCAN : ST_HOLD;
        end
    end

    // Next values of the registered outputs and scan datapath.
    always_comb begin
        w_idx_nxt   = r_idx;
`ifdef DECODER_N_TO_2N_SEQ_SCAN_EN
        w_cnt_nxt   = r_cnt;
        w_dwell_nxt = r_dwell;
        w_wrap_nxt  = 1'b0;
`endif
        if (bus.stop) begin
            w_idx_nxt = '0;
`ifdef DECODER_N_TO_2N_SEQ_SCAN_EN
            w_cnt_nxt = '0;
`endif
        end else if (w_accept) begin
            w_idx_nxt = bus.sel;
`ifdef DECODER_N_TO_2N_SEQ_SCAN_EN
            if (w_scan_req) begin
                w_cnt_nxt   = bus.dwell;
                w_dwell_nxt = bus.dwell;
            end
`endif
        end
`ifdef DECODER_N_TO_2N_SEQ_SCAN_EN
        else if (bus.en && (r_state == ST_SCAN)) begin
            if (r_cnt == '0) begin
                w_idx_nxt  = r_idx + 1'b1;
                w_cnt_nxt  = r_dwell;
                w_wrap_nxt = &r_idx;
            end else begin
                w_cnt_nxt  = r_cnt - 1'b1;
            end
        end
`endif

        w_d_nxt = '0;
        if (!bus.stop && bus.en && (w_state_nxt != ST_IDLE)) begin
            w_d_nxt = {{(OUT_W-1){1'b0}}, 1'b1} << w_idx_nxt;
        end
    end
endmodule

// File: tb/tb_decoder_n_to_2n_seq.sv
// Directed bench for decoder_n_to_2n_seq (SEL_W=2, DWELL_W=4).
// Scan-mode steps are built only when DECODER_N_TO_2N_SEQ_SCAN_EN is defined.
module tb_decoder_n_to_2n_seq;
    logic clk = 1'b0;
    logic rst_n;
    int   n_pass  = 0;
    int   n_total = 0;

    decoder_n_to_2n_seq_if #(.SEL_W(2), .DWELL_W(4)) bus ();

    decoder_n_to_2n_seq #(.SEL_W(2), .DWELL_W(4)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic chk_out(input string tag, input logic [3:0] d, input logic [1:0] idx,
                           input logic ready, input logic wrap);
        chk({tag, ".d"},     32'(bus.d),     32'(d));
        chk({tag, ".idx"},   32'(bus.idx),   32'(idx));
        chk({tag, ".ready"}, 32'(bus.ready), 32'(ready));
        chk({tag, ".wrap"},  32'(bus.wrap),  32'(wrap));
        chk({tag, ".onehot"}, 32'($countones(bus.d) <= 1), 32'd1);
    endtask

    initial begin
        rst_n     = 1'b0;
        bus.en    = 1'b1;
        bus.load  = 1'b1;
        bus.mode  = 1'b0;
        bus.sel   = 2'd2;
        bus.dwell = 4'd0;
        bus.stop  = 1'b0;
        #2;
        tick();
        chk_out("reset_override", 4'b0000, 2'd0, 1'b1, 1'b0);

        rst_n = 1'b1;
        tick();
        chk_out("direct_sel2", 4'b0100, 2'd2, 1'b1, 1'b0);

        bus.load = 1'b0;
        tick();
        chk_out("hold_sel2", 4'b0100, 2'd2, 1'b1, 1'b0);

        bus.en = 1'b0;
        tick();
        chk_out("hold_en_low", 4'b0000, 2'd2, 1'b1, 1'b0);

        bus.en = 1'b1;
        tick();
        chk_out("hold_en_back", 4'b0100, 2'd2, 1'b1, 1'b0);

        bus.en   = 1'b0;
        bus.load = 1'b1;
        bus.sel  = 2'd1;
        tick();
        chk_out("load_en_low", 4'b0000, 2'd1, 1'b1, 1'b0);

        bus.en   = 1'b1;
        bus.load = 1'b0;
        tick();
        chk_out("after_load_en_low", 4'b0010, 2'd1, 1'b1, 1'b0);

        bus.stop = 1'b1;
        bus.load = 1'b1;
        bus.sel  = 2'd3;
        tick();
        chk_out("stop_beats_load_hold", 4'b0000, 2'd0, 1'b1, 1'b0);

        bus.stop = 1'b0;
        bus.load = 1'b0;
        tick();
        chk_out("idle_after_stop", 4'b0000, 2'd0, 1'b1, 1'b0);

        bus.load  = 1'b1;
        bus.mode  = 1'b1;
        bus.sel   = 2'd3;
        bus.dwell = 4'd1;
`ifdef DECODER_N_TO_2N_SEQ_SCAN_EN
        tick();
        chk_out("scan_start", 4'b1000, 2'd3, 1'b0, 1'b0);
        bus.load = 1'b0;
        tick();
        chk_out("scan_dwell3", 4'b1000, 2'd3, 1'b0, 1'b0);
        tick();
        chk_out("scan_wrap", 4'b0001, 2'd0, 1'b0, 1'b1);
        tick();
        chk_out("scan_dwell0", 4'b0001, 2'd0, 1'b0, 1'b0);
        tick();
        chk_out("scan_idx1_a", 4'b0010, 2'd1, 1'b0, 1'b0);
        tick();
        chk_out("scan_idx1_b", 4'b0010, 2'd1, 1'b0, 1'b0);

        rst_n    = 1'b0;
        bus.load = 1'b1;
        tick();
        chk_out("reset_mid_scan", 4'b0000, 2'd0, 1'b1, 1'b0);

        rst_n     = 1'b1;
        bus.mode  = 1'b1;
        bus.sel   = 2'd0;
        bus.dwell = 4'd0;
        tick();
        chk_out("fast_start", 4'b0001, 2'd0, 1'b0, 1'b0);
        bus.load = 1'b0;
        tick();
        chk_out("fast_step1", 4'b0010, 2'd1, 1'b0, 1'b0);
        bus.en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_out("fast_frozen", 4'b0000, 2'd1, 1'b0, 1'b0);
        end
        bus.en = 1'b1;
        tick();
        chk_out("fast_resume", 4'b0100, 2'd2, 1'b0, 1'b0);
        tick();
        chk_out("fast_step3", 4'b1000, 2'd3, 1'b0, 1'b0);
        tick();
        chk_out("fast_wrap", 4'b0001, 2'd0, 1'b0, 1'b1);

        bus.stop = 1'b1;
        bus.load = 1'b1;
        bus.mode = 1'b0;
        bus.sel  = 2'd2;
        tick();
        chk_out("stop_beats_load_scan", 4'b0000, 2'd0, 1'b1, 1'b0);
        bus.stop = 1'b0;
        bus.load = 1'b0;
        tick();
        chk_out("idle_after_scan_stop", 4'b0000, 2'd0, 1'b1, 1'b0);
`else
        tick();
        chk_out("mode1_direct", 4'b1000, 2'd3, 1'b1, 1'b0);
        bus.load = 1'b0;
        tick();
        chk_out("mode1_hold_a", 4'b1000, 2'd3, 1'b1, 1'b0);
        tick();
        chk_out("mode1_hold_b", 4'b1000, 2'd3, 1'b1, 1'b0);

        bus.load  = 1'b1;
        bus.sel   = 2'd1;
        bus.dwell = 4'd0;
        tick();
        chk_out("mode1_reload", 4'b0010, 2'd1, 1'b1, 1'b0);
        bus.load = 1'b0;
        tick();
        chk_out("mode1_no_step", 4'b0010, 2'd1, 1'b1, 1'b0);

        rst_n    = 1'b0;
        bus.load = 1'b1;
        tick();
        chk_out("reset_in_hold", 4'b0000, 2'd0, 1'b1, 1'b0);
        rst_n    = 1'b1;
        bus.mode = 1'b0;
        bus.sel  = 2'd2;
        tick();
        chk_out("direct_sel2_rerun", 4'b0100, 2'd2, 1'b1, 1'b0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
